// File: rtl/alu_issue_stage.sv
// ID/EX register feeding the ALU: opcode->select decode, operand B mux, optional forwarding (ALU_ISSUE_FWD_EN).
// Latency: 1 cycle from accepted input to out_valid.
// Backpressure: single entry; in_ready drops while held and not drained, on load-use stall, on flush, or in reset.
module alu_issue_stage #(
  parameter int word_size     = 16,
  parameter int op_size       = 4,
  parameter int reg_addr_size = 3,
  parameter int imm_size      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [op_size-1:0]       in_opcode,
  input  logic [reg_addr_size-1:0] in_rs,
  input  logic [reg_addr_size-1:0] in_rt,
  input  logic [reg_addr_size-1:0] in_rd,
  input  logic [word_size-1:0]     in_rs_data,
  input  logic [word_size-1:0]     in_rt_data,
  input  logic [imm_size-1:0]      in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [word_size-1:0]     alu_data_1,
  output logic [word_size-1:0]     alu_data_2,
  output logic [op_size-1:0]       alu_sel,
  output logic [word_size-1:0]     out_store_data,
  output logic [reg_addr_size-1:0] out_rd,
  output logic [op_size-1:0]       out_opcode,
  input  logic                     ex_mem_wen,
  input  logic                     ex_mem_is_load,
  input  logic [reg_addr_size-1:0] ex_mem_rd,
  input  logic [word_size-1:0]     ex_mem_data,
  input  logic                     mem_wb_wen,
  input  logic [reg_addr_size-1:0] mem_wb_rd,
  input  logic [word_size-1:0]     mem_wb_data
);

  localparam logic [op_size-1:0] OP_NONE = op_size'(0);
  localparam logic [op_size-1:0] OP_LW   = op_size'(1);
  localparam logic [op_size-1:0] OP_LB   = op_size'(2);
  localparam logic [op_size-1:0] OP_SW   = op_size'(3);
  localparam logic [op_size-1:0] OP_SB   = op_size'(4);
  localparam logic [op_size-1:0] OP_AND  = op_size'(5);
  localparam logic [op_size-1:0] OP_OR   = op_size'(6);
  localparam logic [op_size-1:0] OP_ADD  = op_size'(7);
  localparam logic [op_size-1:0] OP_SUB  = op_size'(8);
  localparam logic [op_size-1:0] OP_SLT  = op_size'(9);
  localparam logic [op_size-1:0] OP_BEQ  = op_size'(10);
  localparam logic [op_size-1:0] OP_ADDI = op_size'(12);

  logic                 stall;
  logic                 capture;
  logic [word_size-1:0] rs_op;
  logic [word_size-1:0] rt_op;
  logic [word_size-1:0] imm_sext;
  logic [word_size-1:0] nxt_data_1;
  logic [word_size-1:0] nxt_data_2;
  logic [op_size-1:0]   nxt_sel;

`ifdef ALU_ISSUE_FWD_EN
  // Operand sourcing with forwarding: EX/MEM beats MEM/WB beats register file; r0 is always zero.
  always_comb begin
    rs_op = in_rs_data;
    rt_op = in_rt_data;
    stall = 1'b0;
    if (in_rs == '0) begin
      rs_op = '0;
    end else if (ex_mem_wen && (ex_mem_rd == in_rs)) begin
      rs_op = ex_mem_data;
      stall = ex_mem_is_load;
    end else if (mem_wb_wen && (mem_wb_rd == in_rs)) begin
      rs_op = mem_wb_data;
    end
    if (in_rt == '0) begin
      rt_op = '0;
    end else if (ex_mem_wen && (ex_mem_rd == in_rt)) begin
      rt_op = ex_mem_data;
      stall = stall | ex_mem_is_load;
    end else if (mem_wb_wen && (mem_wb_rd == in_rt)) begin
      rt_op = mem_wb_data;
    end
  end
`else
  // Forwarding sources are ignored in this build; fold them into a sink so they are visibly unused.
  logic unused_fwd;
  assign unused_fwd = ^{ex_mem_wen, ex_mem_is_load, ex_mem_rd, ex_mem_data,
                        mem_wb_wen, mem_wb_rd, mem_wb_data};

  // Operand sourcing straight from the register file; r0 is always zero.
  always_comb begin
    rs_op = (in_rs == '0) ? '0 : in_rs_data;
    rt_op = (in_rt == '0) ? '0 : in_rt_data;
    stall = 1'b0;
  end
`endif

  assign imm_sext = {{(word_size-imm_size){in_imm[imm_size-1]}}, in_imm};

  // Opcode decode: ALU select code and operand pair for the incoming instruction.
  always_comb begin
    nxt_sel    = OP_NONE;
    nxt_data_1 = '0;
    nxt_data_2 = '0;
    case (in_opcode)
      OP_LW, OP_LB, OP_SW, OP_SB, OP_ADDI: begin
        nxt_sel    = OP_ADD;
        nxt_data_1 = rs_op;
        nxt_data_2 = imm_sext;
      end
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: begin
        nxt_sel    = in_opcode;
        nxt_data_1 = rs_op;
        nxt_data_2 = rt_op;
      end
      OP_BEQ: begin
        nxt_sel    = OP_SUB;
        nxt_data_1 = rs_op;
        nxt_data_2 = rt_op;
      end
      default: begin
        nxt_sel    = OP_NONE;
        nxt_data_1 = '0;
        nxt_data_2 = '0;
      end
    endcase
  end

  assign in_ready = rst_n & (~out_valid | out_ready) & ~stall & ~flush;
  assign capture  = in_valid & in_ready;

  // Single-entry pipeline register: reset, then flush, then capture, then drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      alu_data_1     <= '0;
      alu_data_2     <= '0;
      alu_sel        <= '0;
      out_store_data <= '0;
      out_rd         <= '0;
      out_opcode     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid      <= 1'b1;
      alu_data_1     <= nxt_data_1;
      alu_data_2     <= nxt_data_2;
      alu_sel        <= nxt_sel;
      out_store_data <= rt_op;
      out_rd         <= in_rd;
      out_opcode     <= in_opcode;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, handshake, flush, reset, and forwarding when ALU_ISSUE_FWD_EN is set.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_opcode, alu_sel, out_opcode;
  logic [2:0]  in_rs, in_rt, in_rd, out_rd;
  logic [15:0] in_rs_data, in_rt_data, alu_data_1, alu_data_2, out_store_data;
  logic [7:0]  in_imm;
  logic        ex_mem_wen, ex_mem_is_load, mem_wb_wen;
  logic [2:0]  ex_mem_rd, mem_wb_rd;
  logic [15:0] ex_mem_data, mem_wb_data;

  int checks   = 0;
  int failures = 0;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_data_1(alu_data_1), .alu_data_2(alu_data_2), .alu_sel(alu_sel),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_opcode(out_opcode),
    .ex_mem_wen(ex_mem_wen), .ex_mem_is_load(ex_mem_is_load),
    .ex_mem_rd(ex_mem_rd), .ex_mem_data(ex_mem_data),
    .mem_wb_wen(mem_wb_wen), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] rs, input logic [15:0] rsd,
                       input logic [2:0] rt, input logic [15:0] rtd, input logic [7:0] imm,
                       input logic [2:0] rd);
    in_opcode  = op;
    in_rs      = rs;
    in_rs_data = rsd;
    in_rt      = rt;
    in_rt_data = rtd;
    in_imm     = imm;
    in_rd      = rd;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    ex_mem_wen = 1'b0; ex_mem_is_load = 1'b0; ex_mem_rd = '0; ex_mem_data = '0;
    mem_wb_wen = 1'b0; mem_wb_rd = '0; mem_wb_data = '0;
    drive(4'b0111, 3'd1, 16'h0005, 3'd2, 16'h0003, 8'h00, 3'd4);

    // Reset state
    tick; tick;
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_in_ready", {15'd0, in_ready}, 16'd0);
    check("rst_data_1", alu_data_1, 16'h0000);
    check("rst_sel", {12'd0, alu_sel}, 16'd0);

    // ADD r1=5, r2=3
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", {15'd0, in_ready}, 16'd1);
    tick;
    check("add_valid", {15'd0, out_valid}, 16'd1);
    check("add_sel", {12'd0, alu_sel}, 16'h0007);
    check("add_d1", alu_data_1, 16'h0005);
    check("add_d2", alu_data_2, 16'h0003);
    check("add_rd", {13'd0, out_rd}, 16'd4);
    check("add_opcode", {12'd0, out_opcode}, 16'h0007);

    // ADDI with negative immediate
    drive(4'b1100, 3'd1, 16'h0010, 3'd2, 16'h1234, 8'hFC, 3'd3);
    tick;
    check("addi_sel", {12'd0, alu_sel}, 16'h0007);
    check("addi_d1", alu_data_1, 16'h0010);
    check("addi_d2", alu_data_2, 16'hFFFC);

    // LW with largest positive immediate
    drive(4'b0001, 3'd6, 16'h0200, 3'd2, 16'h1234, 8'h7F, 3'd5);
    tick;
    check("lw_sel", {12'd0, alu_sel}, 16'h0007);
    check("lw_d2", alu_data_2, 16'h007F);

    // BEQ maps to SUB
    drive(4'b1010, 3'd3, 16'h0009, 3'd4, 16'h0009, 8'h00, 3'd0);
    tick;
    check("beq_sel", {12'd0, alu_sel}, 16'h0008);
    check("beq_d2", alu_data_2, 16'h0009);

    // JUMP zeroes everything
    drive(4'b1011, 3'd3, 16'hAAAA, 3'd4, 16'h5555, 8'h12, 3'd0);
    tick;
    check("jump_sel", {12'd0, alu_sel}, 16'h0000);
    check("jump_d1", alu_data_1, 16'h0000);
    check("jump_d2", alu_data_2, 16'h0000);

    // SW: address from rs+imm, store data from rt
    drive(4'b0011, 3'd1, 16'h0100, 3'd5, 16'hBEEF, 8'h04, 3'd0);
    tick;
    check("sw_d1", alu_data_1, 16'h0100);
    check("sw_d2", alu_data_2, 16'h0004);
    check("sw_store", out_store_data, 16'hBEEF);

    // r0 reads as zero; undefined opcode yields zero select
    drive(4'b0111, 3'd0, 16'hFFFF, 3'd2, 16'h0001, 8'h00, 3'd1);
    tick;
    check("r0_d1", alu_data_1, 16'h0000);
    check("r0_d2", alu_data_2, 16'h0001);
    drive(4'b1111, 3'd1, 16'h1111, 3'd2, 16'h2222, 8'h00, 3'd1);
    tick;
    check("undef_sel", {12'd0, alu_sel}, 16'h0000);
    check("undef_d1", alu_data_1, 16'h0000);

    // Hold for 3 cycles, then back-to-back load
    drive(4'b1000, 3'd1, 16'h0020, 3'd2, 16'h0008, 8'h00, 3'd6);
    tick;
    check("sub_sel", {12'd0, alu_sel}, 16'h0008);
    out_ready = 1'b0;
    drive(4'b0101, 3'd3, 16'h00F0, 3'd4, 16'h0F0F, 8'h00, 3'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_in_ready", {15'd0, in_ready}, 16'd0);
      tick;
      check("hold_valid", {15'd0, out_valid}, 16'd1);
      check("hold_sel", {12'd0, alu_sel}, 16'h0008);
      check("hold_d1", alu_data_1, 16'h0020);
      check("hold_rd", {13'd0, out_rd}, 16'd6);
    end
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", {15'd0, in_ready}, 16'd1);
    tick;
    check("b2b_valid", {15'd0, out_valid}, 16'd1);
    check("b2b_sel", {12'd0, alu_sel}, 16'h0005);
    check("b2b_d2", alu_data_2, 16'h0F0F);

    // Drain
    in_valid = 1'b0;
    tick;
    check("drain_valid", {15'd0, out_valid}, 16'd0);

    // Flush with held entry and pending input
    in_valid = 1'b1;
    drive(4'b0111, 3'd1, 16'h0001, 3'd2, 16'h0002, 8'h00, 3'd3);
    tick;
    out_ready = 1'b0;
    flush = 1'b1;
    drive(4'b0110, 3'd1, 16'h0044, 3'd2, 16'h0055, 8'h00, 3'd5);
    #1;
    check("flush_in_ready", {15'd0, in_ready}, 16'd0);
    tick;
    check("flush_valid", {15'd0, out_valid}, 16'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick;
    check("flush_no_capture", {15'd0, out_valid}, 16'd0);

    // Reset during hold
    in_valid = 1'b1;
    drive(4'b0111, 3'd1, 16'h00AB, 3'd2, 16'h00CD, 8'h00, 3'd2);
    tick;
    check("prehold_valid", {15'd0, out_valid}, 16'd1);
    rst_n = 1'b0;
    tick;
    check("midrst_valid", {15'd0, out_valid}, 16'd0);
    check("midrst_d1", alu_data_1, 16'h0000);
    check("midrst_d2", alu_data_2, 16'h0000);
    check("midrst_store", out_store_data, 16'h0000);
    check("midrst_rd", {13'd0, out_rd}, 16'd0);
    check("midrst_opcode", {12'd0, out_opcode}, 16'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

`ifdef ALU_ISSUE_FWD_EN
    // EX/MEM forwarding to rs
    ex_mem_wen = 1'b1; ex_mem_rd = 3'd2; ex_mem_data = 16'h00AA;
    drive(4'b0111, 3'd2, 16'h0011, 3'd3, 16'h0022, 8'h00, 3'd1);
    tick;
    check("fwd_exmem_d1", alu_data_1, 16'h00AA);
    check("fwd_rt_regfile", alu_data_2, 16'h0022);
    // Both stages match: EX/MEM wins
    mem_wb_wen = 1'b1; mem_wb_rd = 3'd2; mem_wb_data = 16'h00BB;
    tick;
    check("fwd_priority", alu_data_1, 16'h00AA);
    // MEM/WB only, to rt
    ex_mem_wen = 1'b0; mem_wb_rd = 3'd3;
    tick;
    check("fwd_memwb_d2", alu_data_2, 16'h00BB);
    // r0 never forwarded
    ex_mem_wen = 1'b1; ex_mem_rd = 3'd0; ex_mem_data = 16'h7777;
    drive(4'b0111, 3'd0, 16'h0011, 3'd3, 16'h0022, 8'h00, 3'd1);
    tick;
    check("fwd_r0", alu_data_1, 16'h0000);
    // Load-use stall on rt
    in_valid = 1'b0;
    mem_wb_wen = 1'b0;
    tick;
    in_valid = 1'b1;
    ex_mem_wen = 1'b1; ex_mem_is_load = 1'b1; ex_mem_rd = 3'd3; ex_mem_data = 16'h0999;
    drive(4'b0111, 3'd1, 16'h0001, 3'd3, 16'h0022, 8'h00, 3'd4);
    #1;
    check("ld_use_in_ready", {15'd0, in_ready}, 16'd0);
    tick;
    check("ld_use_no_capture", {15'd0, out_valid}, 16'd0);
    ex_mem_wen = 1'b0; ex_mem_is_load = 1'b0;
    mem_wb_wen = 1'b1; mem_wb_rd = 3'd3; mem_wb_data = 16'h00CC;
    #1;
    check("ld_use_release", {15'd0, in_ready}, 16'd1);
    tick;
    check("ld_use_valid", {15'd0, out_valid}, 16'd1);
    check("ld_use_d2", alu_data_2, 16'h00CC);
`else
    // Forwarding inputs have no effect in this build
    ex_mem_wen = 1'b1; ex_mem_is_load = 1'b1; ex_mem_rd = 3'd2; ex_mem_data = 16'h00AA;
    mem_wb_wen = 1'b1; mem_wb_rd = 3'd3; mem_wb_data = 16'h00BB;
    drive(4'b0111, 3'd2, 16'h0011, 3'd3, 16'h0022, 8'h00, 3'd1);
    #1;
    check("nofwd_no_stall", {15'd0, in_ready}, 16'd1);
    tick;
    check("nofwd_d1", alu_data_1, 16'h0011);
    check("nofwd_d2", alu_data_2, 16'h0022);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
